icache_lock_ctrl: RTL and testbench
===================================

ICACHE_LOCK_CTRL -- requirements
Module: icache_lock_ctrl

Interface
REQ-001 Parameter WAYS, default 4: I-cache associativity.
REQ-002 Parameter IDX_W, default 6: set-index width.
REQ-003 Parameter MAX_LOCK, default 8: lock-table entries.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 lock_start  in  1  new backward-branch loop detected; pulse.
REQ-008 lock_cache  in  1  loop-lock window active, level.
REQ-009 flush  in  1  I-cache invalidate-all.
REQ-010 fill_valid / fill_index / fill_way  in  1 / IDX_W / log2(WAYS)  line fill completed.
REQ-011 hit_valid / hit_index / hit_way  in  1 / IDX_W / log2(WAYS)  fetch hit.
REQ-012 query_index  in  IDX_W  set being considered by replacement.
REQ-013 way_lock_mask  out  WAYS  ways of query_index the replacement shall not victimize.
REQ-014 lock_busy  out  1  state not IDLE.
REQ-015 lock_count  out  log2(MAX_LOCK)+1  valid table entries.
REQ-016 lock_overflow  out  1  one-cycle pulse: candidate dropped (table full or set limit).

Function
REQ-017 States: IDLE, COLLECT, HOLD, DRAIN.
REQ-018 IDLE: lock_start -> COLLECT; table cleared at that edge; events in the lock_start cycle not recorded.
REQ-019 COLLECT: cycle with lock_cache=1 and a candidate -> record {index, way}; visible in way_lock_mask next cycle.
REQ-020 Candidate: fill has priority over hit; at most one record per cycle; losing hit dropped silently (no overflow).
REQ-021 Candidate already in table (same index and way): no new entry, no overflow.
REQ-022 Candidate dropped with overflow pulse if lock_count==MAX_LOCK or its set already has WAYS-1 locked ways.
REQ-023 COLLECT -> HOLD on the edge where lock_count reaches MAX_LOCK.
REQ-024 HOLD: no recording; masks remain; overflow pulses for new non-duplicate candidates while lock_cache=1.
REQ-025 COLLECT/HOLD: lock_cache=0 -> DRAIN; candidate in that cycle not recorded.
REQ-026 COLLECT/HOLD: lock_start=1 -> COLLECT with table cleared; overrides lock_cache=0 in the same cycle.
REQ-027 DRAIN: one cycle, all entries invalidated, -> IDLE; way_lock_mask forced 0 while in DRAIN.
REQ-028 flush in any state: table cleared, -> IDLE next cycle; highest priority over lock_start, fill, hit.
REQ-029 way_lock_mask combinational: OR of one-hot(way) over valid entries with index==query_index; never more than WAYS-1 bits set.
REQ-030 lock_count equals number of valid entries, updated with the table; never exceeds MAX_LOCK.
REQ-031 lock_overflow registered-free: asserted in the cycle the drop decision is made.

Reset
REQ-032 rst: state IDLE, all entries invalid, lock_count 0, way_lock_mask 0, lock_busy 0, lock_overflow 0.
REQ-033 rst mid-COLLECT/HOLD: same result; no partial entries survive.

Structure
REQ-034 Package icache_lock_pkg: state enum, entry struct {valid, index, way}, default parameter constants.
REQ-035 Sub-module icache_lock_table: entry storage, duplicate match, per-set lock count, query mask; FSM and candidate arbitration in icache_lock_ctrl.
REQ-036 No memories; flops only; all storage reset.

Verification
REQ-037 lock_start, then lock_cache=1 with fills (idx 3, way 1), (idx 3, way 2) -> query_index=3 gives mask 4'b0110 the cycle after the second fill; lock_count=2.
REQ-038 Set limit: fills idx 5, ways 0,1,2,3 -> first three recorded, fourth: lock_overflow=1, mask 4'b0111.
REQ-039 Fill (idx 7, way 0) and hit (idx 9, way 2) same cycle -> only idx 7 recorded, no overflow; repeat fill (idx 7, way 0) -> count unchanged.
REQ-040 Nine distinct candidates, MAX_LOCK=8 -> HOLD after the eighth; ninth pulses overflow; lock_cache=0 -> DRAIN one cycle, then IDLE, count 0.
REQ-041 flush with lock_start in the same cycle during COLLECT -> IDLE next cycle, table empty; rst mid-HOLD -> all outputs at reset values.

Source files
------------

// File: rtl/icache_lock_pkg.sv
// Shared types and default sizing for the I-cache loop-lock controller.
// Entries hold index/way at fixed maximum widths so the struct stays parameter-free.
package icache_lock_pkg;

    localparam int DEF_WAYS     = 4;
    localparam int DEF_IDX_W    = 6;
    localparam int DEF_MAX_LOCK = 8;

    // Upper bounds on IDX_W and log2(WAYS) that a stored entry can represent
    localparam int ENT_IDX_W = 16;
    localparam int ENT_WAY_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_HOLD,
        ST_DRAIN
    } lock_state_e;

    typedef struct packed {
        logic                 valid;
        logic [ENT_IDX_W-1:0] index;
        logic [ENT_WAY_W-1:0] way;
    } lock_entry_t;

endpackage

// File: rtl/icache_lock_table.sv
// Lock table storage: allocates entries, flags duplicates and full sets,
// and produces the locked-way mask for the set under replacement.
module icache_lock_table
    import icache_lock_pkg::*;
#(
    parameter int WAYS     = DEF_WAYS,
    parameter int IDX_W    = DEF_IDX_W,
    parameter int MAX_LOCK = DEF_MAX_LOCK,
    localparam int WAY_W   = $clog2(WAYS),
    localparam int CNT_W   = $clog2(MAX_LOCK) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] cand_index,
    input  logic [WAY_W-1:0] cand_way,
    input  logic [IDX_W-1:0] query_index,
    output logic             cand_dup,
    output logic             cand_set_full,
    output logic [WAYS-1:0]  query_mask,
    output logic [CNT_W-1:0] count
);

    localparam int SET_W = WAY_W + 1;

    lock_entry_t entry_q [MAX_LOCK];
    lock_entry_t entry_d [MAX_LOCK];
    logic [SET_W-1:0] set_cnt;

    // New entries go into the lowest free slot; the controller never writes when full.
    always_comb begin
        logic placed;
        placed  = 1'b0;
        entry_d = entry_q;
        for (int i = 0; i < MAX_LOCK; i++) begin
            if (wr_en && !placed && !entry_q[i].valid) begin
                entry_d[i].valid = 1'b1;
                entry_d[i].index = ENT_IDX_W'(cand_index);
                entry_d[i].way   = ENT_WAY_W'(cand_way);
                placed           = 1'b1;
            end
        end
        if (clear) begin
            for (int i = 0; i < MAX_LOCK; i++) begin
                entry_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_LOCK; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            entry_q <= entry_d;
        end
    end

    always_comb begin
        cand_dup   = 1'b0;
        set_cnt    = '0;
        count      = '0;
        query_mask = '0;
        for (int i = 0; i < MAX_LOCK; i++) begin
            if (entry_q[i].valid) begin
                count = count + CNT_W'(1);
                if (entry_q[i].index == ENT_IDX_W'(cand_index)) begin
                    set_cnt = set_cnt + SET_W'(1);
                    if (entry_q[i].way == ENT_WAY_W'(cand_way)) begin
                        cand_dup = 1'b1;
                    end
                end
                for (int w = 0; w < WAYS; w++) begin
                    if (entry_q[i].index == ENT_IDX_W'(query_index) &&
                        entry_q[i].way == ENT_WAY_W'(w)) begin
                        query_mask[w] = 1'b1;
                    end
                end
            end
        end
    end

    // At least one way per set must stay available to the replacement policy
    assign cand_set_full = (set_cnt >= SET_W'(WAYS - 1));

endmodule

// File: rtl/icache_lock_ctrl.sv
// Loop-lock controller: records filled/hit lines during a loop-lock window so
// the replacement policy leaves them alone until the window closes.
module icache_lock_ctrl
    import icache_lock_pkg::*;
#(
    parameter int WAYS     = DEF_WAYS,
    parameter int IDX_W    = DEF_IDX_W,
    parameter int MAX_LOCK = DEF_MAX_LOCK,
    localparam int WAY_W   = $clog2(WAYS),
    localparam int CNT_W   = $clog2(MAX_LOCK) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lock_start,
    input  logic             lock_cache,
    input  logic             flush,
    input  logic             fill_valid,
    input  logic [IDX_W-1:0] fill_index,
    input  logic [WAY_W-1:0] fill_way,
    input  logic             hit_valid,
    input  logic [IDX_W-1:0] hit_index,
    input  logic [WAY_W-1:0] hit_way,
    input  logic [IDX_W-1:0] query_index,
    output logic [WAYS-1:0]  way_lock_mask,
    output logic             lock_busy,
    output logic [CNT_W-1:0] lock_count,
    output logic             lock_overflow
);

    lock_state_e      state_q, state_d;
    logic             table_clear;
    logic             record_en;
    logic             capture_ok;
    logic             new_cand;
    logic             cand_dup;
    logic             cand_set_full;
    logic [IDX_W-1:0] cand_index;
    logic [WAY_W-1:0] cand_way;
    logic [WAYS-1:0]  query_mask;
    logic [CNT_W-1:0] table_count;

    icache_lock_table #(
        .WAYS     (WAYS),
        .IDX_W    (IDX_W),
        .MAX_LOCK (MAX_LOCK)
    ) u_table (
        .clk           (clk),
        .rst           (rst),
        .clear         (table_clear),
        .wr_en         (record_en),
        .cand_index    (cand_index),
        .cand_way      (cand_way),
        .query_index   (query_index),
        .cand_dup      (cand_dup),
        .cand_set_full (cand_set_full),
        .query_mask    (query_mask),
        .count         (table_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // flush beats everything; lock_start restarts collection even when lock_cache drops
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (lock_start) begin
                        state_d = ST_COLLECT;
                    end
                end
                ST_COLLECT, ST_HOLD: begin
                    if (lock_start) begin
                        state_d = ST_COLLECT;
                    end else if (!lock_cache) begin
                        state_d = ST_DRAIN;
                    end else if (state_q == ST_COLLECT && record_en &&
                                 table_count == CNT_W'(MAX_LOCK - 1)) begin
                        state_d = ST_HOLD;
                    end
                end
                ST_DRAIN: state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cand_index    = fill_valid ? fill_index : hit_index;
        cand_way      = fill_valid ? fill_way   : hit_way;
        capture_ok    = (state_q == ST_COLLECT || state_q == ST_HOLD) &&
                        lock_cache && !lock_start && !flush && !rst;
        new_cand      = capture_ok && (fill_valid || hit_valid) && !cand_dup;
        lock_overflow = new_cand && (state_q == ST_HOLD || cand_set_full ||
                                     table_count == CNT_W'(MAX_LOCK));
        record_en     = new_cand && !lock_overflow;
        table_clear   = flush || lock_start || (state_q == ST_DRAIN);
        lock_busy     = (state_q != ST_IDLE);
        lock_count    = table_count;
        way_lock_mask = (state_q == ST_DRAIN) ? '0 : query_mask;
    end

endmodule

// File: tb/tb_icache_lock_ctrl.sv
// Scoreboard bench for icache_lock_ctrl: a queue-based lock-table model predicts
// every cycle's outputs and a negedge monitor compares them against the DUT.
module tb_icache_lock_ctrl;

    localparam int WAYS     = 4;
    localparam int IDX_W    = 6;
    localparam int MAX_LOCK = 8;
    localparam int WAY_W    = 2;
    localparam int CNT_W    = 4;

    localparam int M_IDLE    = 0;
    localparam int M_COLLECT = 1;
    localparam int M_HOLD    = 2;
    localparam int M_DRAIN   = 3;

    logic             clk;
    logic             rst;
    logic             lock_start;
    logic             lock_cache;
    logic             flush;
    logic             fill_valid;
    logic [IDX_W-1:0] fill_index;
    logic [WAY_W-1:0] fill_way;
    logic             hit_valid;
    logic [IDX_W-1:0] hit_index;
    logic [WAY_W-1:0] hit_way;
    logic [IDX_W-1:0] query_index;
    logic [WAYS-1:0]  way_lock_mask;
    logic             lock_busy;
    logic [CNT_W-1:0] lock_count;
    logic             lock_overflow;

    typedef struct {
        bit              chk;
        logic [WAYS-1:0] mask;
        int              count;
        bit              busy;
        bit              ovf;
    } exp_t;

    exp_t sb_q[$];
    int   ent_idx[$];
    int   ent_way[$];
    int   mode;
    int   n_checks;
    int   n_fail;

    icache_lock_ctrl #(
        .WAYS     (WAYS),
        .IDX_W    (IDX_W),
        .MAX_LOCK (MAX_LOCK)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .lock_start    (lock_start),
        .lock_cache    (lock_cache),
        .flush         (flush),
        .fill_valid    (fill_valid),
        .fill_index    (fill_index),
        .fill_way      (fill_way),
        .hit_valid     (hit_valid),
        .hit_index     (hit_index),
        .hit_way       (hit_way),
        .query_index   (query_index),
        .way_lock_mask (way_lock_mask),
        .lock_busy     (lock_busy),
        .lock_count    (lock_count),
        .lock_overflow (lock_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit inTable(input int idx, input int way);
        for (int i = 0; i < ent_idx.size(); i++) begin
            if (ent_idx[i] == idx && ent_way[i] == way) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int setCount(input int idx);
        int n = 0;
        for (int i = 0; i < ent_idx.size(); i++) begin
            if (ent_idx[i] == idx) n++;
        end
        return n;
    endfunction

    function automatic logic [WAYS-1:0] maskFor(input int idx);
        logic [WAYS-1:0] m = '0;
        for (int i = 0; i < ent_idx.size(); i++) begin
            if (ent_idx[i] == idx) m[ent_way[i]] = 1'b1;
        end
        return m;
    endfunction

    // Drive one cycle of inputs, predict that cycle's outputs, then advance the model
    task automatic applyStimulus(input bit r, input bit ls, input bit lc, input bit fl,
                                 input bit fv, input int fi, input int fw,
                                 input bit hv, input int hi, input int hw, input int qi);
        exp_t e;
        bit   active;
        bit   rec;
        bit   ovf;
        int   ci;
        int   cw;
        @(posedge clk);
        #1;
        rst         = r;
        lock_start  = ls;
        lock_cache  = lc;
        flush       = fl;
        fill_valid  = fv;
        fill_index  = IDX_W'(fi);
        fill_way    = WAY_W'(fw);
        hit_valid   = hv;
        hit_index   = IDX_W'(hi);
        hit_way     = WAY_W'(hw);
        query_index = IDX_W'(qi);

        e.chk   = !r;
        e.busy  = (mode != M_IDLE);
        e.count = ent_idx.size();
        e.mask  = (mode == M_DRAIN) ? '0 : maskFor(qi);
        active  = !r && !fl && !ls && lc && (mode == M_COLLECT || mode == M_HOLD);
        ci      = fv ? fi : hi;
        cw      = fv ? fw : hw;
        rec     = 1'b0;
        ovf     = 1'b0;
        if (active && (fv || hv) && !inTable(ci, cw)) begin
            if (mode == M_HOLD || ent_idx.size() == MAX_LOCK || setCount(ci) >= WAYS - 1)
                ovf = 1'b1;
            else
                rec = 1'b1;
        end
        e.ovf = ovf;
        sb_q.push_back(e);

        if (r || fl) begin
            ent_idx.delete(); ent_way.delete(); mode = M_IDLE;
        end else if (mode == M_IDLE) begin
            if (ls) begin ent_idx.delete(); ent_way.delete(); mode = M_COLLECT; end
        end else if (mode == M_DRAIN) begin
            ent_idx.delete(); ent_way.delete(); mode = M_IDLE;
        end else if (ls) begin
            ent_idx.delete(); ent_way.delete(); mode = M_COLLECT;
        end else if (!lc) begin
            mode = M_DRAIN;
        end else begin
            if (rec) begin ent_idx.push_back(ci); ent_way.push_back(cw); end
            if (mode == M_COLLECT && ent_idx.size() == MAX_LOCK) mode = M_HOLD;
        end
    endtask

    task automatic idleCycle(input bit lc, input int qi);
        applyStimulus(0, 0, lc, 0, 0, 0, 0, 0, 0, 0, qi);
    endtask

    task automatic fillCycle(input int fi, input int fw, input int qi);
        applyStimulus(0, 0, 1, 0, 1, fi, fw, 0, 0, 0, qi);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.chk) begin
                    checkOutput("sb_busy",  int'(lock_busy),     int'(e.busy));
                    checkOutput("sb_count", int'(lock_count),    e.count);
                    checkOutput("sb_ovf",   int'(lock_overflow), int'(e.ovf));
                    checkOutput("sb_mask",  int'(way_lock_mask), int'(e.mask));
                end
            end
        end
    end

    initial begin : stimulus
        n_checks = 0;
        n_fail   = 0;
        mode     = M_IDLE;
        rst = 1'b1; lock_start = 1'b0; lock_cache = 1'b0; flush = 1'b0;
        fill_valid = 1'b0; fill_index = '0; fill_way = '0;
        hit_valid = 1'b0; hit_index = '0; hit_way = '0; query_index = '0;

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idleCycle(0, 0);
        @(negedge clk);
        checkOutput("reset_busy",  int'(lock_busy), 0);
        checkOutput("reset_count", int'(lock_count), 0);
        checkOutput("reset_ovf",   int'(lock_overflow), 0);

        // Two fills into set 3; the fill alongside lock_start must be ignored
        applyStimulus(0, 1, 1, 0, 1, 3, 1, 0, 0, 0, 3);
        fillCycle(3, 1, 3);
        @(negedge clk);
        checkOutput("start_fill_ignored", int'(lock_count), 0);
        fillCycle(3, 2, 3);
        @(negedge clk);
        checkOutput("first_fill_mask", int'(way_lock_mask), 4'b0010);
        idleCycle(1, 3);
        @(negedge clk);
        checkOutput("two_fill_mask",  int'(way_lock_mask), 4'b0110);
        checkOutput("two_fill_count", int'(lock_count), 2);

        // Per-set limit: fourth way of set 5 is refused
        for (int w = 0; w < 3; w++) fillCycle(5, w, 5);
        fillCycle(5, 3, 5);
        @(negedge clk);
        checkOutput("set_limit_ovf",  int'(lock_overflow), 1);
        checkOutput("set_limit_mask", int'(way_lock_mask), 4'b0111);

        // Fill beats hit silently, duplicate fill adds nothing
        applyStimulus(0, 0, 1, 0, 1, 7, 0, 1, 9, 2, 9);
        @(negedge clk);
        checkOutput("fill_vs_hit_ovf", int'(lock_overflow), 0);
        fillCycle(7, 0, 7);
        @(negedge clk);
        checkOutput("dup_count", int'(lock_count), 6);
        checkOutput("dup_ovf",   int'(lock_overflow), 0);
        idleCycle(1, 9);
        @(negedge clk);
        checkOutput("lost_hit_mask", int'(way_lock_mask), 0);
        checkOutput("after_dup_count", int'(lock_count), 6);

        // Fill the table, overflow in HOLD, then close the window
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 10);
        for (int k = 0; k < 9; k++) fillCycle(10 + k, 0, 10);
        @(negedge clk);
        checkOutput("full_count", int'(lock_count), 8);
        checkOutput("full_ovf",   int'(lock_overflow), 1);
        fillCycle(10, 0, 10);
        @(negedge clk);
        checkOutput("hold_dup_ovf", int'(lock_overflow), 0);
        idleCycle(0, 10);
        @(negedge clk);
        checkOutput("hold_mask", int'(way_lock_mask), 4'b0001);
        idleCycle(0, 10);
        @(negedge clk);
        checkOutput("drain_mask", int'(way_lock_mask), 0);
        checkOutput("drain_busy", int'(lock_busy), 1);
        idleCycle(0, 10);
        @(negedge clk);
        checkOutput("idle_busy",  int'(lock_busy), 0);
        checkOutput("idle_count", int'(lock_count), 0);

        // flush together with lock_start wins
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 20);
        fillCycle(20, 1, 20);
        fillCycle(21, 2, 20);
        applyStimulus(0, 1, 1, 1, 1, 22, 3, 0, 0, 0, 20);
        idleCycle(1, 20);
        @(negedge clk);
        checkOutput("flush_busy",  int'(lock_busy), 0);
        checkOutput("flush_count", int'(lock_count), 0);
        checkOutput("flush_mask",  int'(way_lock_mask), 0);

        // Reset from HOLD
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 30);
        for (int k = 0; k < 8; k++) fillCycle(30 + k, 1, 30);
        applyStimulus(1, 0, 1, 0, 1, 40, 0, 0, 0, 0, 30);
        fillCycle(41, 0, 30);
        @(negedge clk);
        checkOutput("rst_hold_busy",  int'(lock_busy), 0);
        checkOutput("rst_hold_count", int'(lock_count), 0);
        checkOutput("rst_hold_mask",  int'(way_lock_mask), 0);
        checkOutput("rst_hold_ovf",   int'(lock_overflow), 0);

        for (int n = 0; n < 800; n++) begin
            applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 24) == 0,
                          $urandom_range(0, 9) != 0, $urandom_range(0, 59) == 0,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 5), $urandom_range(0, 3),
                          $urandom_range(0, 1) == 1, $urandom_range(0, 5), $urandom_range(0, 3),
                          $urandom_range(0, 5));
        end

        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
        #1;
        checkOutput("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
